// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared mode encoding for the LFSR/rotator generator
package lfsr_pkg;
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        LFSR = 2'b01,
        ROR  = 2'b10,
        ROL  = 2'b11
    } lfsr_mode_t;
endpackage

// File: rtl/tick_div.sv
// tick_div: free-running clock divider producing a registered one-cycle strobe
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable (count holds while low)
//   clr        : synchronous count clear (does not cancel a pulse already due)
//   tick       : high the cycle after the count reaches DIV-1
module tick_div #(
    parameter int unsigned DIV = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    logic [CW-1:0] count;
    logic at_last;
    assign at_last = count == LAST;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            // with DIV=1 the count never leaves 0, so tick stays high while en=1
            tick  <= en && at_last;
            count <= clr ? '0 : en ? (at_last ? '0 : count + 1'b1) : count;
        end
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: tick-driven LFSR / rotate register with seed load handshake
//   clk, rst_n            : clock, asynchronous active-low reset
//   en                    : enables the tick divider
//   mode                  : 00 HOLD, 01 LFSR, 10 ROR, 11 ROL
//   step                  : one-cycle manual advance, independent of en
//   load_valid/load_data  : seed load request, accepted when load_ready=1
//   load_ready            : drops for one cycle after each accepted load
//   q, tick               : registered contents and divider pulse
//   lockup                : LFSR mode with all-zero contents
// Optional: define LFSR_LOCKUP_RECOVER_EN to reload SEED when advancing a zero LFSR.
module lfsr_gen import lfsr_pkg::*; #(
    parameter int                 WIDTH = 8,
    parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0]   SEED  = WIDTH'(8'h01),
    parameter int unsigned        DIV   = 5_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             step,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             lockup
);
    lfsr_mode_t       m;
    logic             accept;
    logic             advance;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] nxt;
    assign m       = lfsr_mode_t'(mode);
    assign accept  = load_valid && load_ready;
    // tick and step in the same cycle are a single advance
    assign advance = tick || step;
    assign lockup  = (m == LFSR) && (q == '0);
    tick_div #(.DIV(DIV)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clr  (accept),
        .tick (tick)
    );
    always_comb begin
        shifted = (m == LFSR) ? {^(q & TAPS), q[WIDTH-1:1]} :
                  (m == ROR)  ? {q[0], q[WIDTH-1:1]} :
                  (m == ROL)  ? {q[WIDTH-2:0], q[WIDTH-1]} : q;
`ifdef LFSR_LOCKUP_RECOVER_EN
        nxt = lockup ? SEED : shifted;
`else
        nxt = shifted;
`endif
    end
    // a load wins over a same-cycle advance
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            q          <= SEED;
            load_ready <= 1'b1;
        end else begin
            q          <= accept ? load_data : advance ? nxt : q;
            load_ready <= !accept;
        end
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed and random checks of lfsr_gen (DIV=4 and DIV=1) against a reference model
module tb_lfsr_gen;
    logic clk = 0, rst_n = 0, en = 0, step = 0, load_valid = 0;
    logic [1:0] mode = 0;
    logic [7:0] load_data = 0;
    logic [7:0] q0, q1;
    logic tick0, tick1, lock0, lock1, rdy0, rdy1;
    int passed = 0, total = 0;
    int div_of[2] = '{4, 1};
    logic [7:0] m_q[2];
    int m_cnt[2];
    logic m_tick[2], m_rdy[2];

    lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step),
        .load_valid(load_valid), .load_data(load_data), .load_ready(rdy0),
        .q(q0), .tick(tick0), .lockup(lock0));
    lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step),
        .load_valid(load_valid), .load_data(load_data), .load_ready(rdy1),
        .q(q1), .tick(tick1), .lockup(lock1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // next value from the mode rules, via shifts and a popcount parity
    function automatic logic [7:0] next_val(input logic [1:0] md, input logic [7:0] v);
        int fb;
`ifdef LFSR_LOCKUP_RECOVER_EN
        if (md == 2'b01 && v == 0) return 8'h01;
`endif
        fb = $countones(v & 8'h1D) % 2;
        if (md == 2'b01) return 8'((fb << 7) | (v >> 1));
        if (md == 2'b10) return 8'((v >> 1) | (v << 7));
        if (md == 2'b11) return 8'((v << 1) | (v >> 7));
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 8'h01; m_cnt[i] = 0; m_tick[i] = 0; m_rdy[i] = 1;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            logic acc, adv, nt;
            acc = load_valid && m_rdy[i];
            adv = m_tick[i] || step;
            nt = en && (m_cnt[i] == div_of[i] - 1);
            m_cnt[i] = acc ? 0 : en ? (m_cnt[i] + 1) % div_of[i] : m_cnt[i];
            m_q[i] = acc ? load_data : adv ? next_val(mode, m_q[i]) : m_q[i];
            m_tick[i] = nt;
            m_rdy[i] = !acc;
        end
    endtask

    task automatic check_all();
        chk("q_div4", q0, m_q[0]);
        chk("tick_div4", tick0, m_tick[0]);
        chk("ready_div4", rdy0, m_rdy[0]);
        chk("lockup_div4", lock0, mode == 2'b01 && m_q[0] == 0);
        chk("q_div1", q1, m_q[1]);
        chk("tick_div1", tick1, m_tick[1]);
        chk("ready_div1", rdy1, m_rdy[1]);
        chk("lockup_div1", lock1, mode == 2'b01 && m_q[1] == 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1 model_reset();
        chk("rst_q", q0, 8'h01);
        chk("rst_tick", tick0, 0);
        check_all();
        @(negedge clk) rst_n = 1;
        check_all();
    endtask

    task automatic load(input logic [7:0] d);
        load_valid = 1; load_data = d;
        cyc();
        load_valid = 0;
    endtask

    initial begin
        bit found;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("reset_seed", q0, 8'h01);
        rst_n = 1;
        // LFSR run: tick every 4th cycle, q 01 -> 80 -> 40 -> 20
        mode = 2'b01; en = 1;
        repeat (5) cyc();
        chk("lfsr_first", q0, 8'h80);
        repeat (8) cyc();
        chk("lfsr_third", q0, 8'h20);
        // manual step in ROL with divider stopped
        en = 0;
        load(8'h81);
        mode = 2'b11;
        cyc();
        step = 1; cyc(); step = 0;
        chk("rol_step", q0, 8'h03);
        chk("rol_notick", tick0, 0);
        // load coinciding with a tick
        mode = 2'b01; en = 1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (tick0) found = 1;
            else cyc();
        end
        chk("tick_wait", found, 1);
        load_valid = 1; load_data = 8'hA5;
        cyc();
        chk("load_q", q0, 8'hA5);
        chk("load_ready_low", rdy0, 0);
        cyc();
        load_valid = 0;
        chk("load_ignored", q0, 8'hA5);
        chk("load_ready_back", rdy0, 1);
        repeat (4) cyc();
        // zero seed in LFSR mode
        en = 0;
        load(8'h00);
        cyc();
        chk("lockup_set", lock0, 1);
        step = 1; cyc(); step = 0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        chk("recover_q", q0, 8'h01);
        chk("recover_lockup", lock0, 0);
`else
        chk("stuck_q", q0, 8'h00);
        chk("stuck_lockup", lock0, 1);
`endif
        // reset mid-count
        load(8'h40);
        en = 1;
        repeat (2) cyc();
        @(negedge clk);
        do_reset();
        repeat (3) cyc();
        chk("post_reset_notick", tick0, 0);
        cyc();
        chk("post_reset_tick", tick0, 1);
        // DIV=1 rotate right every cycle
        mode = 2'b10;
        load(8'h01);
        chk("div1_tick", tick1, 1);
        cyc();
        chk("div1_ror1", q1, 8'h80);
        cyc();
        chk("div1_ror2", q1, 8'h40);
        // random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            en = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            step = $urandom_range(0, 4) == 0;
            load_valid = $urandom_range(0, 7) == 0;
            load_data = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                @(negedge clk);
                do_reset();
            end else cyc();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width, legal range 2..32.
REQ-002 SHALL have parameter TAPS, default 8'h1D: feedback tap mask (bits 4,3,2,0), WIDTH bits.
REQ-003 SHALL have parameter SEED, default 8'h01: reset and recovery value, WIDTH bits, nonzero.
REQ-004 SHALL have parameter DIV, default 5_000_000: clock cycles per tick, legal range 1..2^32-1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1 bit: enables the tick divider.
REQ-008 SHALL have port mode, input, 2 bits: 00 HOLD, 01 LFSR, 10 ROR, 11 ROL.
REQ-009 SHALL have port step, input, 1 bit: single-cycle manual advance request, independent of en.
REQ-010 SHALL have port load_valid, input, 1 bit: seed-load request.
REQ-011 SHALL have port load_data, input, WIDTH bits: seed value for a load.
REQ-012 SHALL have port load_ready, output, 1 bit: load acceptance.
REQ-013 SHALL have port q, output, WIDTH bits: register contents, registered.
REQ-014 SHALL have port tick, output, 1 bit: divider pulse, registered.
REQ-015 SHALL have port lockup, output, 1 bit: all-zero indication in LFSR mode.

Function
REQ-016 SHALL count 0..DIV-1 while en=1, hold the count while en=0, and wrap to 0 after DIV-1.
REQ-017 SHALL drive tick high for exactly one cycle, in the cycle after the count reaches DIV-1; with DIV=1, tick SHALL stay high continuously while en=1.
REQ-018 SHALL raise an advance event in a cycle when the internal tick strobe or step is 1; tick and step together SHALL produce one advance, not two.
REQ-019 SHALL update q on an advance as follows: HOLD keeps q; LFSR loads {^(q & TAPS), q[WIDTH-1:1]}; ROR loads {q[0], q[WIDTH-1:1]}; ROL loads {q[WIDTH-2:0], q[WIDTH-1]}.
REQ-020 SHALL accept a load when load_valid and load_ready are both 1; q SHALL equal load_data on the next edge, and the divider count SHALL clear to 0.
REQ-021 SHALL give a load priority over a same-cycle advance; that advance SHALL be discarded.
REQ-022 SHALL deassert load_ready for exactly one cycle after each accepted load and hold it at 1 otherwise; load_valid is ignored while load_ready=0.
REQ-023 SHALL drive lockup = (mode==LFSR) && (q==0).
REQ-024 SHALL take a mode change effect at the next advance; q is not modified by the mode change itself.

Reset
REQ-025 SHALL, with rst_n=0, asynchronously set q=SEED, count=0, tick=0 and load_ready=1; lockup follows from REQ-023.
REQ-026 SHALL abort any pending load or advance on reset mid-operation, with no partial update, and restart counting from 0 after release.

Configuration
REQ-027 SHALL compile in lockup recovery when macro LFSR_LOCKUP_RECOVER_EN is defined: an advance in LFSR mode with q==0 loads SEED instead of 0.
REQ-028 SHALL, when LFSR_LOCKUP_RECOVER_EN is not defined, leave q at 0 on such an advance and hold lockup high until a load, a mode change or reset.

Structure
REQ-029 SHALL place the mode encoding (typedef enum lfsr_mode_t: HOLD, LFSR, ROR, ROL) in shared package lfsr_pkg.
REQ-030 SHALL implement the divider (count, en, one-cycle strobe) as sub-module tick_div, parameterised by DIV.

Verification (WIDTH=8, TAPS=8'h1D, SEED=8'h01, DIV=4)
REQ-031 SHALL cover: reset release, en=1, mode=LFSR -> tick every 4th cycle; q sequence 0x01, 0x80, 0x40, 0x20.
REQ-032 SHALL cover: en=0, mode=ROL, q=0x81, one-cycle step -> q=0x03 next cycle; tick stays 0.
REQ-033 SHALL cover: load_valid with load_data=0xA5 asserted in the same cycle as tick -> q=0xA5, count=0, load_ready=0 for one cycle.
REQ-034 SHALL cover: load 0x00, mode=LFSR, step -> lockup=1; with the macro defined, q=0x01 and lockup=0 afterwards; without the macro, q=0x00 and lockup=1.
REQ-035 SHALL cover: rst_n pulled low mid-count at count=2 with q=0x40 -> q=0x01 and tick=0 immediately; first tick 4 cycles after release.
REQ-036 SHALL cover: DIV=1, en=1, mode=ROR, q=0x01 -> tick constantly 1; q sequence 0x80, 0x40, ... advancing every cycle.
